// File: rtl/cs_resolve.sv
// cs_resolve: sequential carry-resolution unit.
// Takes a carry-save pair (S, C with value S + 2*C) and collapses it to one
// binary word by repeated half-add passes, one pass per clock. Ready/valid on
// both sides, a single operation in flight.
module cs_resolve #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_sum,
   input  logic [N-1:0]  in_carry,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_result,
   output logic          out_ovf,
   output logic [IW-1:0] out_iters
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;

   // Working carry-save pair and pass bookkeeping.
   logic [N-1:0]  s_q;
   logic [N-1:0]  c_q;
   logic          ovf_q;
   logic [IW-1:0] iters_q;

   // Registered handshake and result outputs.
   logic          in_ready_q;
   logic          out_valid_q;
   logic [N-1:0]  res_q;
   logic          res_ovf_q;
   logic [IW-1:0] res_iters_q;

   // Outcome of one half-add pass over the current working pair.
   logic [N-1:0]  sh_d;
   logic [N-1:0]  s_d;
   logic [N-1:0]  c_d;
   logic          ovf_d;
   logic [IW-1:0] iters_d;

   // Pass counter increment that pins at N; the counter can never wrap.
   function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
      if (v >= IW'(N)) begin
         return IW'(N);
      end
      return v + IW'(1);
   endfunction

   // One half-add pass: carry bit i moves up to weight 2^(i+1); the bit
   // shifted out of the top is an overflow of the N-bit result.
   always_comb begin
      sh_d    = {c_q[N-2:0], 1'b0};
      s_d     = s_q ^ sh_d;
      c_d     = s_q & sh_d;
      ovf_d   = ovf_q | c_q[N-1];
      iters_d = sat_inc(iters_q);
   end

   // Control FSM with registered outputs; result registers load only on the
   // transition into DONE so they hold steady through IDLE and ITER.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         res_ovf_q   <= 1'b0;
         res_iters_q <= '0;
         s_q         <= '0;
         c_q         <= '0;
         ovf_q       <= 1'b0;
         iters_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  s_q        <= in_sum;
                  c_q        <= in_carry;
                  ovf_q      <= 1'b0;
                  iters_q    <= '0;
                  in_ready_q <= 1'b0;
                  if (in_carry != '0) begin
                     state_q <= ITER;
                  end else begin
                     // Nothing to resolve: the sum is already the answer.
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     res_q       <= in_sum;
                     res_ovf_q   <= 1'b0;
                     res_iters_q <= '0;
                  end
               end
            end
            ITER: begin
               s_q     <= s_d;
               c_q     <= c_d;
               ovf_q   <= ovf_d;
               iters_q <= iters_d;
               if (c_d == '0) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  res_q       <= s_d;
                  res_ovf_q   <= ovf_d;
                  res_iters_q <= iters_d;
               end
            end
            DONE: begin
               // No same-cycle acceptance: in_ready rises one cycle later.
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_result = res_q;
   assign out_ovf    = res_ovf_q;
   assign out_iters  = res_iters_q;

endmodule

// File: tb/tb_cs_resolve.sv
// Self-checking bench for cs_resolve: directed N=4 cases plus half-adder
// array sweeps at N=4 (full) and N=8 (all a, selected b).
module tb_cs_resolve;

   logic       clk;
   logic       rst;

   logic       iv4, ir4, ov4, or4, ovf4;
   logic [3:0] s4, c4, res4;
   logic [2:0] it4;

   logic       iv8, ir8, ov8, or8, ovf8;
   logic [7:0] s8, c8, res8;
   logic [3:0] it8;

   int n_checks;
   int n_pass;

   cs_resolve #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(iv4), .in_ready(ir4), .in_sum(s4), .in_carry(c4),
      .out_valid(ov4), .out_ready(or4),
      .out_result(res4), .out_ovf(ovf4), .out_iters(it4)
   );

   cs_resolve #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(iv8), .in_ready(ir8), .in_sum(s8), .in_carry(c8),
      .out_valid(ov8), .out_ready(or8),
      .out_result(res8), .out_ovf(ovf8), .out_iters(it8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      iv4 = 1'b0; or4 = 1'b0; s4 = '0; c4 = '0;
      iv8 = 1'b0; or8 = 1'b0; s8 = '0; c8 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if ({ir4, ov4, res4, ovf4, it4} !== {1'b1, 1'b0, 4'd0, 1'b0, 3'd0})
         $display("FAIL reset4 got ir=%b ov=%b res=%h ovf=%b it=%0d need ir=1 ov=0 res=0 ovf=0 it=0",
                  ir4, ov4, res4, ovf4, it4);
      else n_pass++;
      n_checks++;
      if ({ir8, ov8, res8, ovf8, it8} !== {1'b1, 1'b0, 8'd0, 1'b0, 4'd0})
         $display("FAIL reset8 got ir=%b ov=%b res=%h ovf=%b it=%0d need ir=1 ov=0 res=0 ovf=0 it=0",
                  ir8, ov8, res8, ovf8, it8);
      else n_pass++;
   endtask

   // One complete N=4 operation with latency and result checks; the inputs
   // are scrambled after the handshake to show they are not resampled.
   task automatic test_resolve(input string nm, input logic [3:0] s, input logic [3:0] c,
                               input logic [3:0] er, input logic eo, input logic [2:0] ei,
                               input int elat);
      int lat;
      n_checks++;
      if (ir4 !== 1'b1) $display("FAIL %s_ready got %b need 1", nm, ir4);
      else n_pass++;
      s4 = s; c4 = c; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0; s4 = 4'hA; c4 = 4'h7;
      lat = 1;
      while (ov4 !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat != elat) $display("FAIL %s_latency got %0d need %0d", nm, lat, elat);
      else n_pass++;
      n_checks++;
      if ({res4, ovf4, it4} !== {er, eo, ei})
         $display("FAIL %s_result got res=%b ovf=%b it=%0d need res=%b ovf=%b it=%0d",
                  nm, res4, ovf4, it4, er, eo, ei);
      else n_pass++;
      n_checks++;
      if (ir4 !== 1'b0) $display("FAIL %s_busy got in_ready=%b need 0", nm, ir4);
      else n_pass++;
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
      n_checks++;
      if ({ov4, ir4} !== 2'b01)
         $display("FAIL %s_release got ov=%b ir=%b need ov=0 ir=1", nm, ov4, ir4);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      int lat;
      s4 = 4'b0101; c4 = 4'b0101; iv4 = 1'b1; or4 = 1'b0;
      @(posedge clk); #1;
      iv4 = 1'b0;
      lat = 1;
      while (ov4 !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({ov4, ir4, res4, ovf4, it4} !== {1'b1, 1'b0, 4'b1111, 1'b0, 3'd1})
            $display("FAIL bp_hold%0d got ov=%b ir=%b res=%b ovf=%b it=%0d need ov=1 ir=0 res=1111 ovf=0 it=1",
                     i, ov4, ir4, res4, ovf4, it4);
         else n_pass++;
         @(posedge clk); #1;
      end
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
      n_checks++;
      if ({ov4, ir4} !== 2'b01)
         $display("FAIL bp_release got ov=%b ir=%b need ov=0 ir=1", ov4, ir4);
      else n_pass++;
      n_checks++;
      if (res4 !== 4'b1111) $display("FAIL bp_idle_hold got res=%b need 1111", res4);
      else n_pass++;
   endtask

   task automatic test_reset_mid_iter();
      s4 = 4'b1111; c4 = 4'b0001; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({ov4, ir4} !== 2'b00)
         $display("FAIL rst_iter_busy got ov=%b ir=%b need ov=0 ir=0", ov4, ir4);
      else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if ({ir4, ov4, res4, ovf4, it4} !== {1'b1, 1'b0, 4'd0, 1'b0, 3'd0})
         $display("FAIL rst_iter_clear got ir=%b ov=%b res=%b ovf=%b it=%0d need ir=1 ov=0 res=0 ovf=0 it=0",
                  ir4, ov4, res4, ovf4, it4);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({ir4, ov4} !== 2'b10)
         $display("FAIL rst_iter_discard got ir=%b ov=%b need ir=1 ov=0", ir4, ov4);
      else n_pass++;
      test_resolve("after_rst", 4'b0101, 4'b0101, 4'b1111, 1'b0, 3'd1, 2);
   endtask

   task automatic test_sweep4();
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            logic [4:0] exp;
            int  cyc;
            bit  seen, done, hs;
            exp = 5'(a + b);
            iv4 = 1'b0;
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
            s4 = 4'(a ^ b); c4 = 4'(a & b); iv4 = 1'b1;
            @(posedge clk); #1;
            iv4 = 1'b0;
            seen = 0; done = 0; cyc = 0;
            while (!done && cyc < 60) begin
               if (ov4 === 1'b1 && !seen) begin
                  seen = 1;
                  n_checks++;
                  if ({ovf4, res4} !== exp || it4 > 3'd4)
                     $display("FAIL sweep4 a=%0d b=%0d got ovf=%b res=%0d it=%0d need %0d it<=4",
                              a, b, ovf4, res4, it4, exp);
                  else n_pass++;
               end
               or4 = 1'($urandom_range(0, 1));
               hs = (ov4 === 1'b1) && or4;
               @(posedge clk); #1;
               cyc++;
               if (hs) done = 1;
            end
            or4 = 1'b0;
            if (!done) begin
               n_checks++;
               $display("FAIL sweep4_timeout a=%0d b=%0d got no handshake need one", a, b);
            end
         end
      end
   endtask

   task automatic test_sweep8();
      for (int a = 0; a < 256; a++) begin
         for (int j = 0; j < 17; j++) begin
            logic [8:0] exp;
            int  b, cyc;
            bit  seen, done, hs;
            b = (j == 16) ? 1 : j * 17;
            exp = 9'(a + b);
            iv8 = 1'b0;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            s8 = 8'(a ^ b); c8 = 8'(a & b); iv8 = 1'b1;
            @(posedge clk); #1;
            iv8 = 1'b0;
            seen = 0; done = 0; cyc = 0;
            while (!done && cyc < 60) begin
               if (ov8 === 1'b1 && !seen) begin
                  seen = 1;
                  n_checks++;
                  if ({ovf8, res8} !== exp || it8 > 4'd8)
                     $display("FAIL sweep8 a=%0d b=%0d got ovf=%b res=%0d it=%0d need %0d it<=8",
                              a, b, ovf8, res8, it8, exp);
                  else n_pass++;
               end
               or8 = ($urandom_range(0, 3) != 0);
               hs = (ov8 === 1'b1) && or8;
               @(posedge clk); #1;
               cyc++;
               if (hs) done = 1;
            end
            or8 = 1'b0;
            if (!done) begin
               n_checks++;
               $display("FAIL sweep8_timeout a=%0d b=%0d got no handshake need one", a, b);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_resolve("case1", 4'b0101, 4'b0101, 4'b1111, 1'b0, 3'd1, 2);
      test_resolve("case2", 4'b1111, 4'b0001, 4'b0001, 1'b1, 3'd4, 5);
      test_resolve("case3", 4'b0110, 4'b0000, 4'b0110, 1'b0, 3'd0, 1);
      test_back_pressure();
      test_reset_mid_iter();
      test_sweep4();
      test_sweep8();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
